tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: stall cycles allowed mid-message before forced release; 0 disables the timeout.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a_valid  input  1  source A byte available.
REQ-005 a_data  input  8  source A byte.
REQ-006 a_last  input  1  source A byte is final byte of message.
REQ-007 a_ready  output  1  source A byte accepted this cycle when a_valid=1.
REQ-008 b_valid, b_data[7:0], b_last inputs; b_ready output: source B, same meaning as REQ-004..007.
REQ-009 tx_data  output  8  byte to UART transmitter.
REQ-010 new_tx_data  output  1  one-cycle strobe; UART loads tx_data.
REQ-011 tx_busy  input  1  UART transmitting; rises one cycle after new_tx_data.
REQ-012 grant  output  2  one-hot owner: bit0 = A, bit1 = B; 00 = none.
REQ-013 abort  output  1  one-cycle pulse on timeout release.

Function
REQ-014 The block SHALL share one UART transmitter between A and B, holding the grant for a whole message, from first byte until the byte with last=1 is accepted.
REQ-015 States SHALL be IDLE, SEND, ISSUE, GAP.
REQ-016 IDLE: grant=00; if exactly one valid is high, that source SHALL be granted; if both are high, the source not granted most recently SHALL win; next state SEND, grant visible from the SEND cycle.
REQ-017 SEND: ready of the granted source = !tx_busy (combinational); accept = ready && valid; on accept, data and last SHALL be captured and the next state SHALL be ISSUE.
REQ-018 ISSUE: new_tx_data=1 for exactly this cycle, tx_data = captured byte; next state GAP.
REQ-019 GAP: tx_busy SHALL be ignored this cycle; next state IDLE with grant released if captured last=1, else SEND.
REQ-020 tx_data SHALL hold its value until the next ISSUE.
REQ-021 Latency: valid high in IDLE with tx_busy=0 -> ready at cycle+1 -> new_tx_data at cycle+2; peak throughput one byte per 3 cycles.
REQ-022 The non-granted source's ready SHALL be 0 in all states; both readies SHALL be 0 outside SEND.
REQ-023 A request arriving during the other source's message SHALL wait; after release at least one IDLE cycle SHALL precede the new grant.
REQ-024 Stall counter: increments in SEND each cycle granted valid=0 and tx_busy=0; clears on accept and on leaving SEND; cycles with tx_busy=1 SHALL NOT count.
REQ-025 When the stall counter reaches TIMEOUT (TIMEOUT>0): abort=1 for one cycle, grant released, state IDLE, that source recorded as most recent; no new_tx_data is issued.
REQ-026 A single-byte message (last=1 on first byte) SHALL be legal and release after GAP.
REQ-027 last=1 arriving while tx_busy=1 SHALL NOT release the grant until the byte is accepted.

Reset
REQ-028 While rst=1 and on the following cycle: state IDLE, grant=00, a_ready=b_ready=0, new_tx_data=0, tx_data=8'h00, abort=0, stall counter 0, most-recent = B so A wins the first tie.
REQ-029 Reset mid-message SHALL discard the captured byte and the grant; the partial message SHALL NOT resume.

Verification
REQ-030 A sends "HI" (8'h48, 8'h49 last), tx_busy tied 0 -> a_ready at cycles 1 and 4, new_tx_data at 2 and 5 with tx_data 48 then 49, grant=01 cycles 1..6, then 00.
REQ-031 A and B both valid from reset -> A message first; B granted after A's GAP plus one IDLE cycle; next tie after that goes to A.
REQ-032 B sends 3 bytes, tx_busy held high 10 cycles after each new_tx_data -> b_ready stays 0 while busy; exactly 3 strobes in order; no abort.
REQ-033 TIMEOUT=4, A sends one non-last byte then drops valid -> abort pulses 4 cycles into the SEND stall, grant 01 -> 00, no further strobe; pending B granted next.
REQ-034 rst asserted in ISSUE of a multi-byte A message -> next cycle all outputs at REQ-028 values; A's remaining bytes require a new arbitration.

Source files
------------

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_arbiter
//  Description : Shares one byte-wide UART transmitter between two message
//                sources (A and B). A source keeps the grant for a whole
//                message, from its first byte until the byte flagged last
//                has been accepted. Ties go to the source that was not
//                granted most recently. A stall watchdog releases a grant
//                whose source stops supplying bytes mid-message.
//
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                a_valid/a_data/a_last    source A byte stream (in)
//                a_ready                  source A byte accepted (out)
//                b_valid/b_data/b_last    source B byte stream (in)
//                b_ready                  source B byte accepted (out)
//                tx_data, new_tx_data     byte and load strobe to the UART
//                tx_busy                  UART transmitting (in)
//                grant[1:0]               one-hot owner, bit0 = A, bit1 = B
//                abort                    one-cycle pulse on watchdog release
//
//  Parameters  : TIMEOUT  stall cycles tolerated mid-message; 0 disables
//
//  Revision    : 1.0  initial release
// ============================================================================
module tx_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    input  logic       a_last,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    input  logic       b_last,
    output logic       b_ready,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       abort
);

    // Counter only has to reach TIMEOUT-1 before the release fires.
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_STALL_LAST = c_CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [c_CNT_W-1:0] c_STALL_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_STALL_ZERO = '0;
    localparam logic               c_WD_ENABLE  = (TIMEOUT > 0);

    localparam logic [1:0] c_GRANT_NONE = 2'b00;
    localparam logic [1:0] c_GRANT_A    = 2'b01;
    localparam logic [1:0] c_GRANT_B    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        ISSUE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [1:0]         r_grant,    w_grant_nxt;
    logic               r_last_b,   w_last_b_nxt;   // most recent grant went to B
    logic [7:0]         r_tx_data,  w_tx_data_nxt;
    logic               r_last,     w_last_nxt;     // captured byte closes the message
    logic               r_abort,    w_abort_nxt;
    logic [c_CNT_W-1:0] r_stall,    w_stall_nxt;

    logic       w_sel_valid;
    logic [7:0] w_sel_data;
    logic       w_sel_last;
    logic       w_ready;
    logic       w_accept;
    logic       w_stall_cyc;
    logic       w_timeout;
    logic       w_pick_b;

    // Granted source's byte stream; grant is one-hot or zero.
    assign w_sel_valid = (r_grant[0] & a_valid) | (r_grant[1] & b_valid);
    assign w_sel_data  = r_grant[1] ? b_data : a_data;
    assign w_sel_last  = r_grant[1] ? b_last : a_last;

    // Ready depends on tx_busy combinationally so a byte can be taken in
    // the same cycle the UART frees up.
    assign w_ready  = (r_state == SEND) & ~tx_busy;
    assign a_ready  = w_ready & r_grant[0];
    assign b_ready  = w_ready & r_grant[1];
    assign w_accept = w_ready & w_sel_valid;

    // A stall cycle is one where the UART could take a byte but the owner
    // has none; cycles spent waiting on the UART are not the source's fault.
    assign w_stall_cyc = (r_state == SEND) & ~w_sel_valid & ~tx_busy;
    assign w_timeout   = c_WD_ENABLE & w_stall_cyc & (r_stall == c_STALL_LAST);

    // Arbitration: lone requester wins; on a tie the other source than the
    // one granted last wins.
    assign w_pick_b = b_valid & (~a_valid | ~r_last_b);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_b_nxt  = r_last_b;
        w_tx_data_nxt = r_tx_data;
        w_last_nxt    = r_last;
        w_abort_nxt   = 1'b0;
        w_stall_nxt   = c_STALL_ZERO;

        case (r_state)
            IDLE: begin
                if (a_valid | b_valid) begin
                    w_grant_nxt  = w_pick_b ? c_GRANT_B : c_GRANT_A;
                    w_last_b_nxt = w_pick_b;
                    w_state_nxt  = SEND;
                end
            end

            SEND: begin
                if (w_accept) begin
                    w_tx_data_nxt = w_sel_data;
                    w_last_nxt    = w_sel_last;
                    w_state_nxt   = ISSUE;
                end else if (w_timeout) begin
                    // Owner already recorded as most recent at grant time.
                    w_grant_nxt = c_GRANT_NONE;
                    w_abort_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_stall_cyc && c_WD_ENABLE) begin
                    w_stall_nxt = r_stall + c_STALL_ONE;
                end else begin
                    w_stall_nxt = r_stall;
                end
            end

            ISSUE: begin
                w_state_nxt = GAP;
            end

            GAP: begin
                // tx_busy is still rising here, so it is not looked at.
                if (r_last) begin
                    w_grant_nxt = c_GRANT_NONE;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SEND;
                end
            end

            default: begin
                w_grant_nxt = c_GRANT_NONE;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= c_GRANT_NONE;
            r_last_b  <= 1'b1;
            r_tx_data <= 8'h00;
            r_last    <= 1'b0;
            r_abort   <= 1'b0;
            r_stall   <= c_STALL_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last_b  <= w_last_b_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_last    <= w_last_nxt;
            r_abort   <= w_abort_nxt;
            r_stall   <= w_stall_nxt;
        end
    end

    assign grant       = r_grant;
    assign tx_data     = r_tx_data;
    assign new_tx_data = (r_state == ISSUE);
    assign abort       = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_arbiter
//  Description : Self-checking bench for tx_arbiter (TIMEOUT = 4). Directed
//                table and hand sequences for exact cycle behaviour, then
//                randomized traffic checked by a transaction-level model:
//                per-source byte streams, arbitration fairness, message
//                atomicity and ready/strobe rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tx_arbiter;

    localparam int c_TIMEOUT = 4;

    logic       clk;
    logic       rst;
    logic       a_valid, a_last, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [7:0] b_data;
    logic [7:0] tx_data;
    logic       new_tx_data, tx_busy, abort;
    logic [1:0] grant;

    tx_arbiter #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_last     (a_last),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_last     (b_last),
        .b_ready    (b_ready),
        .tx_data    (tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"},   32'(grant),       32'h0);
        chk({tag, "_a_ready"}, 32'(a_ready),     32'h0);
        chk({tag, "_b_ready"}, 32'(b_ready),     32'h0);
        chk({tag, "_new"},     32'(new_tx_data), 32'h0);
        chk({tag, "_tx_data"}, 32'(tx_data),     32'h0);
        chk({tag, "_abort"},   32'(abort),       32'h0);
    endtask

    task automatic clear_inputs();
        a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0;
        b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
        tx_busy = 1'b0;
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle out of reset).
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed table: A sends "HI" with tx_busy low.
    // ------------------------------------------------------------------
    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       al;
        logic       ear;
        logic       enew;
        logic [7:0] etx;
        logic [1:0] egr;
    } vec_t;

    vec_t tbl [9];

    // ------------------------------------------------------------------
    // Randomized traffic model state
    // ------------------------------------------------------------------
    logic [8:0] qa[$], qb[$];     // {last,data} still to be offered
    logic [8:0] ea[$], eb[$];     // {last,data} still to appear on the UART
    int         gap_a, gap_b, busy_cnt;
    int         gap_max, busy_min, busy_max;
    logic       acc_prev;
    logic [7:0] acc_byte;
    logic       strobe_prev;
    logic [1:0] prev_grant;
    logic       prev_av, prev_bv;
    logic       recent_b;         // source granted most recently is B
    logic       open_a, open_b;   // mid-message after a non-last accept
    int         n_strobes;

    task automatic model_init();
        gap_a = 0; gap_b = 0; busy_cnt = 0;
        acc_prev = 1'b0; acc_byte = 8'h00; strobe_prev = 1'b0;
        prev_grant = 2'b00; prev_av = 1'b0; prev_bv = 1'b0;
        recent_b = 1'b1; open_a = 1'b0; open_b = 1'b0;
        n_strobes = 0;
    endtask

    task automatic auto_cycle();
        logic [8:0] tmp;
        logic [1:0] exp_w;
        next_cycle();
        a_valid = (gap_a == 0) && (qa.size() > 0);
        if (a_valid) begin a_data = qa[0][7:0]; a_last = qa[0][8]; end
        if (gap_a > 0) gap_a--;
        b_valid = (gap_b == 0) && (qb.size() > 0);
        if (b_valid) begin b_data = qb[0][7:0]; b_last = qb[0][8]; end
        if (gap_b > 0) gap_b--;
        if (strobe_prev) busy_cnt = $urandom_range(busy_max, busy_min);
        tx_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;

        @(negedge clk);
        if (a_ready) chk("a_ready_rule", 32'({grant, tx_busy}), 32'({2'b01, 1'b0}));
        if (b_ready) chk("b_ready_rule", 32'({grant, tx_busy}), 32'({2'b10, 1'b0}));
        if (acc_prev || new_tx_data) begin
            chk("issue_latency", 32'(new_tx_data), 32'(acc_prev));
            if (acc_prev) chk("issue_data", 32'(tx_data), 32'(acc_byte));
        end
        if (new_tx_data) begin
            n_strobes++;
            if (grant == 2'b01 && ea.size() > 0) begin
                tmp = ea.pop_front();
                chk("a_stream", 32'(tx_data), 32'(tmp[7:0]));
            end else if (grant == 2'b10 && eb.size() > 0) begin
                tmp = eb.pop_front();
                chk("b_stream", 32'(tx_data), 32'(tmp[7:0]));
            end else begin
                chk("strobe_owner_or_extra", 32'({grant, 6'(ea.size()), 6'(eb.size())}), 32'h0);
            end
        end
        if (prev_grant == 2'b00 && (prev_av || prev_bv)) begin
            exp_w = (prev_av && prev_bv) ? (recent_b ? 2'b01 : 2'b10)
                                         : (prev_av ? 2'b01 : 2'b10);
            chk("arbitration", 32'(grant), 32'(exp_w));
            recent_b = (exp_w == 2'b10);
        end
        if (prev_grant != 2'b00 && grant != prev_grant) begin
            chk("release_to_idle", 32'(grant), 32'h0);
            chk("release_msg_done", 32'(prev_grant[0] ? open_a : open_b), 32'h0);
        end
        if (abort) chk("unexpected_abort", 32'(abort), 32'h0);

        acc_prev = 1'b0;
        if (a_valid && a_ready) begin
            acc_prev = 1'b1; acc_byte = a_data; open_a = !a_last;
            void'(qa.pop_front());
            gap_a = $urandom_range(gap_max, 0);
        end
        if (b_valid && b_ready) begin
            acc_prev = 1'b1; acc_byte = b_data; open_b = !b_last;
            void'(qb.pop_front());
            gap_b = $urandom_range(gap_max, 0);
        end
        strobe_prev = new_tx_data;
        prev_grant  = grant;
        prev_av     = a_valid;
        prev_bv     = b_valid;
    endtask

    task automatic run_auto(input int exp_strobes);
        int guard;
        guard = 0;
        while ((qa.size() + qb.size() + ea.size() + eb.size()) > 0 && guard < 5000) begin
            auto_cycle();
            guard++;
        end
        repeat (4) auto_cycle();
        chk("drain_in_time", 32'(guard < 5000), 32'h1);
        chk("strobe_count", 32'(n_strobes), 32'(exp_strobes));
    endtask

    logic [1:0] exp_g31 [10];
    logic       exp_n31 [10];
    logic [1:0] exp_g33 [11];
    logic       exp_ab33[11];
    logic       exp_n33 [11];

    initial begin
        int total;
        int len;
        rst = 1'b1;
        clear_inputs();

        //           av    ad     al    ear   enew  etx    egr
        tbl[0] = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
        tbl[1] = '{1'b1, 8'h48, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01};
        tbl[2] = '{1'b1, 8'h49, 1'b1, 1'b0, 1'b1, 8'h48, 2'b01};
        tbl[3] = '{1'b1, 8'h49, 1'b1, 1'b0, 1'b0, 8'h48, 2'b01};
        tbl[4] = '{1'b1, 8'h49, 1'b1, 1'b1, 1'b0, 8'h48, 2'b01};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h49, 2'b01};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h49, 2'b01};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h49, 2'b00};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h49, 2'b00};

        exp_g31  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        exp_n31  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_g33  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        exp_ab33 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_n33  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // ---------------- "HI" from A, busy tied low ----------------
        do_reset();
        for (int c = 0; c < 9; c++) begin
            a_valid = tbl[c].av; a_data = tbl[c].ad; a_last = tbl[c].al;
            @(negedge clk);
            chk($sformatf("hi_a_ready_c%0d", c), 32'(a_ready),     32'(tbl[c].ear));
            chk($sformatf("hi_b_ready_c%0d", c), 32'(b_ready),     32'h0);
            chk($sformatf("hi_new_c%0d", c),     32'(new_tx_data), 32'(tbl[c].enew));
            chk($sformatf("hi_tx_data_c%0d", c), 32'(tx_data),     32'(tbl[c].etx));
            chk($sformatf("hi_grant_c%0d", c),   32'(grant),       32'(tbl[c].egr));
            chk($sformatf("hi_abort_c%0d", c),   32'(abort),       32'h0);
            next_cycle();
        end

        // ---------------- tie from reset: A, then B, then A ----------------
        do_reset();
        a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("tie_grant_c%0d", c), 32'(grant),       32'(exp_g31[c]));
            chk($sformatf("tie_new_c%0d", c),   32'(new_tx_data), 32'(exp_n31[c]));
            if (c == 2) chk("tie_tx_data_a", 32'(tx_data), 32'hA1);
            if (c == 6) chk("tie_tx_data_b", 32'(tx_data), 32'hB1);
            next_cycle();
        end

        // ---------------- watchdog release, pending B next ----------------
        do_reset();
        for (int c = 0; c < 11; c++) begin
            a_valid = (c < 2);  a_data = 8'h55; a_last = 1'b0;
            b_valid = (c < 10); b_data = 8'h66; b_last = 1'b1;
            @(negedge clk);
            chk($sformatf("wd_grant_c%0d", c),   32'(grant),       32'(exp_g33[c]));
            chk($sformatf("wd_abort_c%0d", c),   32'(abort),       32'(exp_ab33[c]));
            chk($sformatf("wd_new_c%0d", c),     32'(new_tx_data), 32'(exp_n33[c]));
            chk($sformatf("wd_b_ready_c%0d", c), 32'(b_ready),     32'(c == 9));
            if (c == 10) chk("wd_tx_data_b", 32'(tx_data), 32'h66);
            next_cycle();
        end

        // ---------------- reset in ISSUE of a multi-byte message ----------------
        do_reset();
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0;
        @(negedge clk);
        next_cycle();                                   // c1: SEND
        @(negedge clk);
        chk("rstmid_a_ready_c1", 32'(a_ready), 32'h1);
        next_cycle();                                   // c2: ISSUE, reset asserted
        a_data = 8'h22; a_last = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rstmid_new_c2", 32'({new_tx_data, tx_data}), 32'({1'b1, 8'h11}));
        next_cycle();                                   // c3: first cycle after reset
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rstmid_c3");
        next_cycle();                                   // c4: fresh arbitration
        @(negedge clk);
        chk("rstmid_grant_c4", 32'({grant, a_ready}), 32'({2'b01, 1'b1}));
        next_cycle();                                   // c5: ISSUE of 8'h22
        a_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_new_c5", 32'({new_tx_data, tx_data}), 32'({1'b1, 8'h22}));
        next_cycle();

        // ---------------- randomized two-source traffic ----------------
        do_reset();
        model_init();
        gap_max = 2; busy_min = 1; busy_max = 5;
        total = 0;
        for (int m = 0; m < 6; m++) begin
            len = $urandom_range(4, 1);
            for (int i = 0; i < len; i++) begin
                qa.push_back({1'(i == len - 1), 8'($urandom)});
                total++;
            end
            len = $urandom_range(4, 1);
            for (int i = 0; i < len; i++) begin
                qb.push_back({1'(i == len - 1), 8'($urandom)});
                total++;
            end
        end
        ea = qa;
        eb = qb;
        run_auto(total);

        // ---------------- B, 3 bytes, UART busy 10 cycles each ----------------
        do_reset();
        model_init();
        gap_max = 0; busy_min = 10; busy_max = 10;
        qb.push_back({1'b0, 8'h31});
        qb.push_back({1'b0, 8'h32});
        qb.push_back({1'b1, 8'h33});
        eb = qb;
        run_auto(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
